uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver for the ECS serial front end. It integrates its own bit-timing counter, so no external baud-clock generator is needed. Supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. Delivers each received character through a held valid/ack handshake with parity, framing and overrun status.

## Interface
Parameters:
- BAUD_DIV, 434: clk cycles per bit (e.g. 50 MHz / 115200); legal range ≥ 4.
- DATA_BITS, 8: data bits per frame, 5–9, sent LSB first.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- uart_rx  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  last accepted character.
- rx_valid  out  1  rx_data and the error flags are valid; held until acknowledged.
- rx_ack  in  1  consumer acknowledge; meaningful only while rx_valid = 1.
- parity_err  out  1  parity mismatch on the current rx_data; always 0 when PARITY = 0.
- frame_err  out  1  a stop bit was sampled low on the current rx_data.
- overrun  out  1  sticky: at least one frame was dropped because rx_valid was still pending.
- busy  out  1  high from start detection until return to IDLE.

## Operation
- Input path: uart_rx passes through a 2-FF synchronizer (reset value 1), then a registered copy for edge detection.
- Start detection: only in IDLE, on a synchronized 1→0 transition. The line must return high before another start can be detected, so a held-low break produces no further frames.
- Bit counter: width $clog2(BAUD_DIV); no wrap beyond BAUD_DIV-1. Data-bit index counter width $clog2(DATA_BITS+1).
- State machine:
  - IDLE: falling edge → START.
  - START: waits BAUD_DIV/2 cycles (integer division), then samples the line. Sample = 1 → false start, return to IDLE with no output. Sample = 0 → DATA.
  - DATA: samples every BAUD_DIV cycles and shifts into bit position i. After DATA_BITS samples → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: samples one bit. Error if XOR(data, parity bit) ≠ (PARITY == 1), i.e. odd parity requires an odd total count of ones.
  - STOP: samples STOP_BITS bits, BAUD_DIV apart. Any low sample sets the frame error for this frame. After the last stop sample → DONE.
  - DONE: one cycle. Commits the frame to the output registers, then → IDLE.
- Commit rules in DONE:
  - rx_valid = 0, or rx_ack = 1 in the same cycle: load rx_data, parity_err and frame_err; set rx_valid = 1.
  - rx_valid = 1 and rx_ack = 0: discard the new frame; outputs stay unchanged; set overrun = 1.
- Handshake:
  - rx_ack while rx_valid = 1 clears rx_valid and overrun on the next cycle, unless a commit occurs in the same cycle (then rx_valid stays 1).
  - rx_ack while rx_valid = 0 is ignored.
- Frames with frame_err or parity_err are still delivered; their data is the bits as sampled.
- Reset (including mid-frame): state → IDLE and counters cleared. Outputs rx_data, rx_valid, parity_err, frame_err, overrun and busy are all 0 on the cycle after rst is sampled high. Synchronizer FFs are set to 1.

## Timing
- Reference point t0 = the cycle in which the edge detector sees the falling edge. This is 2–3 clk after the pin transition (synchronizer latency).
- Start sample: t0 + BAUD_DIV/2.
- Data bit i (0-based) sample: t0 + BAUD_DIV/2 + (i+1)·BAUD_DIV.
- Parity sample: at slot DATA_BITS+1 on the same grid.
- Stop sample k: at the following slots on the same grid.
- DONE is the cycle after the last stop sample; rx_valid rises the cycle after DONE.
- busy rises at t0+1 and falls the cycle after DONE.
- Sustained back-to-back frames at full baud rate are supported. Receiver recovery after the last stop sample is ≤ 3 cycles, well inside half a bit.

## Test plan
Settings for all scenarios: BAUD_DIV = 16, DATA_BITS = 8, PARITY = 2 (even), STOP_BITS = 1.
- Clean frame: drive 0xA5 LSB first with parity bit 0 and a high stop bit. Required: rx_data = 0xA5, rx_valid = 1, parity_err = 0, frame_err = 0. rx_valid rises at t0 + 8 + 10·16 + 2; rx_ack clears it the next cycle.
- Parity error: same frame with parity bit 1. Required: rx_data = 0xA5, parity_err = 1, frame_err = 0.
- Framing error: frame 0x3C with the stop bit held low for one bit time, then the line released high. Required: rx_data = 0x3C, frame_err = 1; no spurious second frame.
- Glitch rejection: a 4-cycle low pulse on an idle line. Required: rx_valid stays 0; busy rises, then falls within 12 cycles.
- Overrun: send 0x11 then 0x22 back-to-back with no rx_ack. Required: rx_data = 0x11, overrun = 1. A single rx_ack then clears rx_valid and overrun. Separate case: rx_ack asserted exactly in DONE of 0x22 gives rx_data = 0x22, rx_valid = 1, overrun = 0.
- Reset mid-frame: assert rst during data bit 3, then send 0x5A. Required: all outputs 0 the cycle after rst; no partial frame delivered; 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - character delivery interface of the UART receiver
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ack;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;
   logic                 busy;

   // receiver side: produces characters and status, consumes the acknowledge
   modport master (
      output rx_data, rx_valid, parity_err, frame_err, overrun, busy,
      input  rx_ack
   );

   // consumer side
   modport slave (
      input  rx_data, rx_valid, parity_err, frame_err, overrun, busy,
      output rx_ack
   );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with integrated bit timing
module uart_rx_param #(
   parameter int BAUD_DIV  = 434,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            uart_rx,
   uart_rx_param_if.master rx_if
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
   localparam logic [IW-1:0] IDX_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] IDX_STOP = IW'(STOP_BITS - 1);
   localparam bit            HAS_PAR  = (PARITY != 0);
   localparam bit            ODD_PAR  = (PARITY == 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic                 sync1_q, sync2_q, prev_q;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_acc_q, perr_acc_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 busy_q, busy_d;
   logic                 tick;
   logic                 par_bad;

   // two-flop synchronizer plus a delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // frame sequencing, sampling and output commit/handshake
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      perr_acc_d = perr_acc_q;
      ferr_acc_d = ferr_acc_q;
      data_d     = data_q;
      valid_d    = valid_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      ovr_d      = ovr_q;

      // START waits half a bit to land on mid-bit, every later slot a full bit
      tick    = (state_q == S_START) ? (cnt_q == CNT_HALF) : (cnt_q == CNT_FULL);
      // odd parity wants an odd total number of ones across data and parity bit
      par_bad = ((^shift_q) ^ sync2_q) != ODD_PAR;

      // an acknowledge only matters while a character is pending
      if (valid_q && rx_if.rx_ack) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d      = '0;
            idx_d      = '0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
            // requiring a 1->0 edge keeps a held-low break from re-triggering
            if (prev_q && !sync2_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = sync2_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (tick) begin
               cnt_d   = '0;
               // LSB arrives first, so shifting right leaves bit i in position i
               shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_DATA) begin
                  idx_d   = '0;
                  state_d = HAS_PAR ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_PARITY: begin
            if (tick) begin
               cnt_d      = '0;
               perr_acc_d = par_bad;
               state_d    = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (tick) begin
               cnt_d = '0;
               if (!sync2_q) begin
                  ferr_acc_d = 1'b1;
               end
               if (idx_q == IDX_STOP) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            // an acknowledge in this same cycle frees the slot for the new frame
            if (!valid_q || rx_if.rx_ack) begin
               data_d  = shift_q;
               perr_d  = HAS_PAR & perr_acc_q;
               ferr_d  = ferr_acc_q;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         perr_acc_q <= 1'b0;
         ferr_acc_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         perr_acc_q <= perr_acc_d;
         ferr_acc_q <= ferr_acc_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_if.rx_data    = data_q;
   assign rx_if.rx_valid   = valid_q;
   assign rx_if.parity_err = perr_q;
   assign rx_if.frame_err  = ferr_q;
   assign rx_if.overrun    = ovr_q;
   assign rx_if.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param
module tb_uart_rx_param;

   localparam int BD = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_rx = 1'b1;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   rise_cyc = 0;
   logic valid_prev = 1'b0;
   logic ack_prev = 1'b0;

   uart_rx_param_if #(.DATA_BITS(8)) rx_if ();

   uart_rx_param #(
      .BAUD_DIV (BD),
      .DATA_BITS(8),
      .PARITY   (2),
      .STOP_BITS(1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .uart_rx(uart_rx),
      .rx_if  (rx_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // monitor: a commit shows up as rx_valid rising, or staying high across an acknowledge
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         valid_prev = 1'b0;
         ack_prev   = 1'b0;
      end else begin
         if (rx_if.rx_valid && (!valid_prev || ack_prev)) begin
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_frame actual data=0x%0h required=none", rx_if.rx_data);
            end else begin
               e = exp_q.pop_front();
               check("mon_data", 32'(rx_if.rx_data), 32'(e.d));
               check("mon_parity_err", 32'(rx_if.parity_err), 32'(e.pe));
               check("mon_frame_err", 32'(rx_if.frame_err), 32'(e.fe));
            end
         end
         valid_prev = rx_if.rx_valid;
         ack_prev   = rx_if.rx_ack;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
      start_cyc = cyc;
      uart_rx = 1'b0;
      idle(BD);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         idle(BD);
      end
      uart_rx = pbit;
      idle(BD);
      uart_rx = stop;
      idle(BD);
      uart_rx = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!rx_if.rx_valid && k < 400) begin
         step();
         k++;
      end
      check(name, 32'(rx_if.rx_valid), 32'd1);
   endtask

   task automatic ack_and_check(input string name);
      rx_if.rx_ack = 1'b1;
      step();
      rx_if.rx_ack = 1'b0;
      check(name, 32'(rx_if.rx_valid), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_data"}, 32'(rx_if.rx_data), 32'd0);
      check({tag, "_rx_valid"}, 32'(rx_if.rx_valid), 32'd0);
      check({tag, "_parity_err"}, 32'(rx_if.parity_err), 32'd0);
      check({tag, "_frame_err"}, 32'(rx_if.frame_err), 32'd0);
      check({tag, "_overrun"}, 32'(rx_if.overrun), 32'd0);
      check({tag, "_busy"}, 32'(rx_if.busy), 32'd0);
   endtask

   initial begin
      int m;
      rx_if.rx_ack = 1'b0;

      // reset state
      step();
      check_all_zero("reset");
      idle(2);
      rst = 1'b0;
      idle(5);

      // clean frame 0xA5, even parity bit 0
      exp_q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
      send_frame(8'hA5, 1'b0, 1'b1);
      wait_valid("clean_valid");
      check("clean_latency", 32'(rise_cyc - start_cyc), 32'd172);
      ack_and_check("clean_ack_clears");
      idle(10);

      // parity error
      exp_q.push_back('{d: 8'hA5, pe: 1'b1, fe: 1'b0});
      send_frame(8'hA5, 1'b1, 1'b1);
      wait_valid("perr_valid");
      ack_and_check("perr_ack_clears");
      idle(10);

      // framing error, stop held low for a bit time then released
      exp_q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
      send_frame(8'h3C, 1'b0, 1'b0);
      wait_valid("ferr_valid");
      ack_and_check("ferr_ack_clears");
      idle(40);
      check("ferr_no_second_frame", 32'(rx_if.rx_valid), 32'd0);

      // glitch rejection: 4-cycle low pulse
      uart_rx = 1'b0;
      idle(4);
      uart_rx = 1'b1;
      m = 0;
      while (!rx_if.busy && m < 8) begin
         step();
         m++;
      end
      check("glitch_busy_rise", 32'(rx_if.busy), 32'd1);
      m = 0;
      while (rx_if.busy && m < 20) begin
         step();
         m++;
      end
      check("glitch_busy_fall_in_12", 32'(m <= 12 && !rx_if.busy), 32'd1);
      idle(30);
      check("glitch_no_valid", 32'(rx_if.rx_valid), 32'd0);

      // overrun: two frames back-to-back, no acknowledge
      exp_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      idle(4);
      check("ovr_valid", 32'(rx_if.rx_valid), 32'd1);
      check("ovr_data_kept", 32'(rx_if.rx_data), 32'h11);
      check("ovr_flag", 32'(rx_if.overrun), 32'd1);
      ack_and_check("ovr_ack_clears_valid");
      check("ovr_ack_clears_flag", 32'(rx_if.overrun), 32'd0);
      idle(10);

      // acknowledge exactly in DONE of the second frame
      exp_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
      exp_q.push_back('{d: 8'h22, pe: 1'b0, fe: 1'b0});
      send_frame(8'h11, 1'b0, 1'b1);
      fork
         send_frame(8'h22, 1'b0, 1'b1);
         begin
            idle(171);
            rx_if.rx_ack = 1'b1;
            step();
            rx_if.rx_ack = 1'b0;
         end
      join
      idle(2);
      check("done_ack_valid", 32'(rx_if.rx_valid), 32'd1);
      check("done_ack_data", 32'(rx_if.rx_data), 32'h22);
      check("done_ack_no_overrun", 32'(rx_if.overrun), 32'd0);

      // reset during data bit 3 of 0x5A, with 0x22 still pending
      uart_rx = 1'b0;
      idle(BD);
      uart_rx = 1'b0;
      idle(BD);
      uart_rx = 1'b1;
      idle(BD);
      uart_rx = 1'b0;
      idle(BD);
      uart_rx = 1'b1;
      idle(BD / 2);
      check("midframe_busy_before_rst", 32'(rx_if.busy), 32'd1);
      rst = 1'b1;
      step();
      check_all_zero("midrst");
      rst = 1'b0;
      idle(30);
      check("midrst_no_partial", 32'(rx_if.rx_valid), 32'd0);
      exp_q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
      send_frame(8'h5A, 1'b0, 1'b1);
      wait_valid("after_rst_valid");
      ack_and_check("after_rst_ack_clears");
      idle(20);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
